// File: rtl/key_note_arbiter.sv
// rtl/key_note_arbiter.sv - monophonic lowest-index-wins key scheduler for one tone generator
// Emits note-on/note-off events over valid/ready and drives the gate level.
module key_note_arbiter #(
  parameter int NKEYS  = 8,
  parameter int IDXW   = 3,
  parameter int GAPCYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_down,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic             ev_on,
  output logic [IDXW-1:0]  ev_note,
  output logic             gate,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ON_REQ, PLAY, OFF_REQ, GAP} state_e;

  state_e          state_q, state_d;
  logic            ev_valid_q, ev_valid_d;
  logic            ev_on_q, ev_on_d;
  logic [IDXW-1:0] ev_note_q, ev_note_d;
  logic            gate_q, gate_d;
  logic            busy_q, busy_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] cur_note_q, cur_note_d;

  logic            sel_found;
  logic [IDXW-1:0] sel;
  logic            cur_held;
  logic            lower_held;
  logic            accept;

  // Descending scan so the lowest held index is the last one written.
  always_comb begin
    sel_found  = 1'b0;
    sel        = '0;
    cur_held   = 1'b0;
    lower_held = 1'b0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (key_down[k]) begin
        sel_found = 1'b1;
        sel       = IDXW'(k);
      end
    end
    for (int k = 0; k < NKEYS; k++) begin
      if (IDXW'(k) == cur_note_q) cur_held = key_down[k];
      if ((IDXW'(k) < cur_note_q) && key_down[k]) lower_held = 1'b1;
    end
  end

  assign accept = ev_valid_q && ev_ready;

  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    gate_d     = gate_q;
    cnt_d      = cnt_q;
    cur_note_d = cur_note_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          cur_note_d = sel;
          ev_valid_d = 1'b1;
          ev_on_d    = 1'b1;
          ev_note_d  = sel;
          state_d    = ON_REQ;
        end
      end
      ON_REQ: begin
        // Releases here are deliberately ignored; the note-on must land first.
        if (accept) begin
          ev_valid_d = 1'b0;
          gate_d     = 1'b1;
          state_d    = PLAY;
        end
      end
      PLAY: begin
        if (!cur_held || lower_held) begin
          ev_valid_d = 1'b1;
          ev_on_d    = 1'b0;
          ev_note_d  = cur_note_q;
          state_d    = OFF_REQ;
        end
      end
      OFF_REQ: begin
        if (accept) begin
          ev_valid_d = 1'b0;
          gate_d     = 1'b0;
          cnt_d      = 4'(GAPCYC);
          state_d    = GAP;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 4'd0;
      cur_note_q <= '0;
    end else begin
      state_q    <= state_d;
      ev_valid_q <= ev_valid_d;
      ev_on_q    <= ev_on_d;
      ev_note_q  <= ev_note_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      cur_note_q <= cur_note_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_on    = ev_on_q;
  assign ev_note  = ev_note_q;
  assign gate     = gate_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_key_note_arbiter.sv
// tb/tb_key_note_arbiter.sv - self-checking bench for key_note_arbiter
// Directed vector table, hand sequences for stall/async reset, and a random protocol checker.
module tb_key_note_arbiter;

  localparam int NKEYS  = 8;
  localparam int IDXW   = 3;
  localparam int GAPCYC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NKEYS-1:0] key_down = '0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic             ev_on;
  logic [IDXW-1:0]  ev_note;
  logic             gate;
  logic             busy;

  key_note_arbiter #(.NKEYS(NKEYS), .IDXW(IDXW), .GAPCYC(GAPCYC)) dut (
    .clk(clk), .rst_n(rst_n), .key_down(key_down), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_on(ev_on), .ev_note(ev_note), .gate(gate), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] keys;
    logic       rdy;
    logic       v;
    logic       on;
    logic [2:0] note;
    logic       g;
    logic       b;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] k, input logic r, input logic v,
                              input logic on, input logic [2:0] n, input logic g, input logic b);
    vec_t e;
    e.keys = k; e.rdy = r; e.v = v; e.on = on; e.note = n; e.g = g; e.b = b;
    vecs.push_back(e);
  endfunction

  // Off-accepting edge plus GAPCYC more GAP cycles, then the return to IDLE.
  function automatic void add_gap(input logic [7:0] k);
    for (int i = 0; i <= GAPCYC; i++) add(k, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    add(k, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  int   cyc;
  int   last_off_cyc;
  int   last_on_note;
  int   on_count;
  logic exp_on_next;
  logic gate_exp;
  logic pv, pon, acc;
  logic [IDXW-1:0] pnote;

  initial begin
    add(8'h00, 1, 0, 0, 0, 0, 0);
    add(8'h20, 1, 1, 1, 5, 0, 1);
    add(8'h20, 1, 0, 0, 0, 1, 1);
    add(8'h20, 1, 0, 0, 0, 1, 1);
    add(8'h00, 1, 1, 0, 5, 1, 1);
    add_gap(8'h04);
    add(8'h04, 1, 1, 1, 2, 0, 1);
    add(8'h24, 1, 0, 0, 0, 1, 1);
    add(8'h24, 1, 0, 0, 0, 1, 1);
    add(8'h20, 1, 1, 0, 2, 1, 1);
    add_gap(8'h20);
    add(8'h20, 1, 1, 1, 5, 0, 1);
    add(8'h20, 1, 0, 0, 0, 1, 1);
    add(8'h24, 1, 1, 0, 5, 1, 1);
    add_gap(8'h24);
    add(8'h24, 1, 1, 1, 2, 0, 1);
    add(8'h24, 1, 0, 0, 0, 1, 1);
    add(8'h20, 1, 1, 0, 2, 1, 1);
    add_gap(8'h20);
    add(8'h20, 1, 1, 1, 5, 0, 1);
    add(8'h20, 1, 0, 0, 0, 1, 1);
    add(8'h20, 0, 0, 0, 0, 1, 1);
    add(8'h00, 0, 1, 0, 5, 1, 1);
    add(8'h00, 0, 1, 0, 5, 1, 1);
    add_gap(8'h00);
    add(8'h08, 1, 1, 1, 3, 0, 1);
    add(8'h48, 1, 0, 0, 0, 1, 1);
    add(8'h48, 1, 0, 0, 0, 1, 1);
    add(8'h40, 1, 1, 0, 3, 1, 1);
    add_gap(8'h40);
    add(8'h40, 1, 1, 1, 6, 0, 1);
    add(8'h40, 1, 0, 0, 0, 1, 1);
    add(8'h00, 1, 1, 0, 6, 1, 1);
    add_gap(8'h00);
    add(8'h81, 1, 1, 1, 0, 0, 1);
    add(8'h81, 1, 0, 0, 0, 1, 1);
    add(8'h80, 1, 1, 0, 0, 1, 1);
    add_gap(8'h80);
    add(8'h80, 1, 1, 1, 7, 0, 1);
    add(8'h80, 1, 0, 0, 0, 1, 1);
    add(8'h00, 1, 1, 0, 7, 1, 1);
    add_gap(8'h00);

    rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_on",    int'(ev_on),    0);
    chk("rst_note",  int'(ev_note),  0);
    chk("rst_gate",  int'(gate),     0);
    chk("rst_busy",  int'(busy),     0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      key_down = vecs[i].keys;
      ev_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), int'(ev_valid), int'(vecs[i].v));
      chk($sformatf("vec%0d_gate", i),  int'(gate),     int'(vecs[i].g));
      chk($sformatf("vec%0d_busy", i),  int'(busy),     int'(vecs[i].b));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_on", i),   int'(ev_on),   int'(vecs[i].on));
        chk($sformatf("vec%0d_note", i), int'(ev_note), int'(vecs[i].note));
      end
    end

    // Note-on stalled 20 cycles; key 4 released mid-stall must not cancel it.
    key_down = 8'h10;
    ev_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      key_down = (i >= 5) ? 8'h00 : 8'h10;
      step();
      chk($sformatf("stall%0d_valid", i), int'(ev_valid), 1);
      chk($sformatf("stall%0d_on", i),    int'(ev_on),    1);
      chk($sformatf("stall%0d_note", i),  int'(ev_note),  4);
      chk($sformatf("stall%0d_gate", i),  int'(gate),     0);
    end
    ev_ready = 1'b1;
    step();
    chk("stall_acc_gate",  int'(gate),     1);
    chk("stall_acc_valid", int'(ev_valid), 0);
    step();
    chk("stall_off_valid", int'(ev_valid), 1);
    chk("stall_off_on",    int'(ev_on),    0);
    chk("stall_off_note",  int'(ev_note),  4);
    wait_idle("stall_idle");

    // Asynchronous reset while a note is playing.
    key_down = 8'h08;
    step();
    step();
    chk("ar_play_gate", int'(gate), 1);
    key_down = 8'h48;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gate",  int'(gate),     0);
    chk("ar_valid", int'(ev_valid), 0);
    chk("ar_busy",  int'(busy),     0);
    step();
    chk("ar_hold_valid", int'(ev_valid), 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_new_valid", int'(ev_valid), 1);
    chk("ar_new_on",    int'(ev_on),    1);
    chk("ar_new_note",  int'(ev_note),  3);

    // Random protocol check from a fresh reset.
    rst_n = 1'b0;
    key_down = '0;
    step();
    rst_n = 1'b1;
    step();
    cyc = 0;
    last_off_cyc = -1000;
    last_on_note = -1;
    on_count = 0;
    exp_on_next = 1'b1;
    gate_exp = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) key_down = NKEYS'($urandom);
      ev_ready = ($urandom_range(0, 3) != 0);
      pv = ev_valid;
      pon = ev_on;
      pnote = ev_note;
      acc = pv && ev_ready;
      step();
      cyc++;
      if (acc) begin
        chk("rand_alternation", int'(pon), int'(exp_on_next));
        if (pon) begin
          chk("rand_gap", int'((cyc - last_off_cyc) >= GAPCYC + 3), 1);
          last_on_note = int'(pnote);
          on_count++;
          gate_exp = 1'b1;
        end else begin
          chk("rand_off_note", int'(pnote), last_on_note);
          last_off_cyc = cyc;
          gate_exp = 1'b0;
        end
        exp_on_next = ~pon;
      end else if (pv) begin
        chk("rand_stall_valid", int'(ev_valid), 1);
        chk("rand_stall_on",    int'(ev_on),    int'(pon));
        chk("rand_stall_note",  int'(ev_note),  int'(pnote));
      end
      if (gate !== gate_exp) chk("rand_gate", int'(gate), int'(gate_exp));
    end
    chk("rand_some_notes", int'(on_count > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
